// File: rtl/char_scanner_pkg.sv
// char_scanner_pkg
//   Shared types and constants for the multi-digit character scanner:
//   the scan state enum, the character code width, the largest supported
//   digit count, and the counter width helper used to size idx and slot.
package char_scanner_pkg;

    // Literals carry a prefix because the top level has a parameter named GAP.
    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } scan_state_t;

    localparam int CHAR_W     = 4;
    localparam int MAX_DIGITS = 8;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/char_blank_mask.sv
// char_blank_mask
//   Combinational blank-vector generator for the character scanner.
//   A digit is blank when its blank_mask bit is set, or, with leading-zero
//   suppression enabled, when it and every more significant digit are zero.
//   Digit 0 is never suppressed so a zero word still shows a single "0".
// Ports:
//   active     in  CHAR_W*DIGITS  displayed word, digit DIGITS-1 most significant
//   blank_mask in  DIGITS         per-digit forced blank
//   blank      out DIGITS         1 = digit i is not shown in its slot
module char_blank_mask
    import char_scanner_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic [CHAR_W*DIGITS-1:0] active,
    input  logic [DIGITS-1:0]        blank_mask,
    output logic [DIGITS-1:0]        blank
);

    logic lead_zero;

    // Walk from the most significant digit down; lead_zero stays set only
    // while every digit seen so far is zero.
    always_comb begin
        lead_zero = 1'b1;
        blank     = blank_mask;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero & (active[CHAR_W*i +: CHAR_W] == '0);
            if ((LZ_SUPPRESS != 0) && (i != 0) && lead_zero) begin
                blank[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_scanner.sv
// char_scanner
//   Parametrised multi-digit character scanner for the 7-segment path.
//   Latches a packed word of 4-bit codes and time-multiplexes it onto a
//   single char output, MSB digit first, DWELL cycles per digit followed by
//   GAP blank cycles. New words are shadowed and only promoted to the
//   displayed word at a frame boundary, so a frame never mixes two words.
// Ports:
//   clock       in  1              rising-edge system clock
//   reset       in  1              synchronous, active-high
//   load        in  1              capture Data_in this cycle
//   Data_in     in  4*DIGITS       packed codes, digit i = Data_in[4i+3:4i]
//   blank_mask  in  DIGITS         live per-digit forced blank
//   char        out 4              current character code (0 when blank)
//   digit_sel   out DIGITS         one-hot digit enable (0 when blank / gap)
//   char_valid  out 1              char/digit_sel drive a visible digit
//   frame_start out 1              pulse on the first output cycle of a frame
module char_scanner
    import char_scanner_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DWELL       = 3,
    parameter int GAP         = 1,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [CHAR_W*DIGITS-1:0] Data_in,
    input  logic [DIGITS-1:0]        blank_mask,
    output logic [CHAR_W-1:0]        char,
    output logic [DIGITS-1:0]        digit_sel,
    output logic                     char_valid,
    output logic                     frame_start
);

    localparam int WORD_W = CHAR_W * DIGITS;
    localparam int IDX_W  = cnt_w(DIGITS);
    localparam int SLOT_W = cnt_w((DWELL > GAP) ? DWELL : GAP);

    localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(DIGITS - 1);
    localparam logic [SLOT_W-1:0] DWELL_LAST = SLOT_W'(DWELL - 1);
    localparam logic [SLOT_W-1:0] GAP_LAST   = SLOT_W'((GAP > 0) ? GAP - 1 : 0);

    scan_state_t       state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx, idx_step;
    logic [SLOT_W-1:0] slot, slot_nx;

    logic [WORD_W-1:0] active;
    logic [WORD_W-1:0] shadow;
    logic              pending;
    logic              boundary;

    logic [DIGITS-1:0] blank;
    logic              visible;
    logic              frame_top;

    logic [CHAR_W-1:0] char_nx;
    logic [DIGITS-1:0] digit_sel_nx;

    logic [CHAR_W-1:0] char_p1;
    logic [DIGITS-1:0] digit_sel_p1;
    logic              vld_p1;
    logic              frame_start_p1;

    char_blank_mask #(
        .DIGITS      (DIGITS),
        .LZ_SUPPRESS (LZ_SUPPRESS)
    ) u_blank (
        .active     (active),
        .blank_mask (blank_mask),
        .blank      (blank)
    );

    // ---- stage p0: scan state, counters, word registers ----

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_SHOW;
            idx   <= IDX_TOP;
            slot  <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            slot  <= slot_nx;
        end
    end

    // Scan order runs MSB first and wraps from digit 0 back to the top.
    assign idx_step = (idx == '0) ? IDX_TOP : idx - IDX_W'(1);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        slot_nx  = slot;
        case (state)
            ST_SHOW: begin
                if (slot == DWELL_LAST) begin
                    slot_nx = '0;
                    if (GAP == 0) begin
                        idx_nx = idx_step;
                    end else begin
                        state_nx = ST_GAP;
                    end
                end else begin
                    slot_nx = slot + SLOT_W'(1);
                end
            end
            ST_GAP: begin
                if (slot == GAP_LAST) begin
                    state_nx = ST_SHOW;
                    idx_nx   = idx_step;
                    slot_nx  = '0;
                end else begin
                    slot_nx = slot + SLOT_W'(1);
                end
            end
            default: begin
                state_nx = ST_SHOW;
                idx_nx   = IDX_TOP;
                slot_nx  = '0;
            end
        endcase
    end

    // The boundary is the edge that lands the scan on the top digit's first
    // slot, i.e. the edge that starts the next frame.
    assign boundary = (state_nx == ST_SHOW) && (idx_nx == IDX_TOP) && (slot_nx == '0);

    // A load on the boundary edge goes straight to the display; any other
    // load is parked in the shadow (last one wins) until the next boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= Data_in;
            end
            if (boundary) begin
                if (load) begin
                    active <= Data_in;
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= load;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Output decode from the pre-edge scan state.
    always_comb begin
        visible      = (state == ST_SHOW) && !blank[idx];
        frame_top    = (state == ST_SHOW) && (idx == IDX_TOP) && (slot == '0);
        char_nx      = '0;
        digit_sel_nx = '0;
        if (visible) begin
            char_nx      = active[CHAR_W*int'(idx) +: CHAR_W];
            digit_sel_nx = DIGITS'(1) << idx;
        end
    end

    // ---- stage p1: registered outputs ----

    always_ff @(posedge clock) begin
        if (reset) begin
            char_p1        <= '0;
            digit_sel_p1   <= '0;
            vld_p1         <= 1'b0;
            frame_start_p1 <= 1'b0;
        end else begin
            char_p1        <= char_nx;
            digit_sel_p1   <= digit_sel_nx;
            vld_p1         <= visible;
            frame_start_p1 <= frame_top;
        end
    end

    assign char        = char_p1;
    assign digit_sel   = digit_sel_p1;
    assign char_valid  = vld_p1;
    assign frame_start = frame_start_p1;

endmodule
